ascon_ctrl: RTL and testbench
=============================

# ascon_ctrl

Sequencing controller for the Ascon-128 round datapath. It steps the shared one-round-per-cycle permutation through the AEAD phases: initialisation, associated data (AD), message, finalisation and tag. It drives the datapath select/enable strobes and the round-constant index, and handshakes with the block source and the tag sink. It holds no data itself; block padding is done upstream.

## Interface
- ROUNDS_A, 12 (ROUND_NO): rounds of p^a; legal 1..12
- ROUNDS_B, 6: rounds of p^b; legal 1..12

- clk_i  in  1  clock; the only clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  begin an operation; sampled only in IDLE
- decrypt_i  in  1  mode, latched with start_i
- ad_empty_i  in  1  no AD blocks, latched with start_i
- abort_i  in  1  synchronous abort, any state
- ad_valid_i / ad_last_i  in  1/1  AD block present / final AD block
- ad_ready_o  out  1  controller accepts an AD block
- msg_valid_i / msg_last_i  in  1/1  message block present / final (padded) block
- msg_ready_o  out  1  controller accepts a message block
- dp_load_init_o  out  1  load IV‖K‖N into state
- dp_round_en_o  out  1  apply one round this cycle
- dp_rnd_o  out  4 (rnd_t)  RndConst index for the current round
- dp_absorb_o  out  1  XOR input block into x0 (replace on decrypt)
- dp_decrypt_o  out  1  latched decrypt flag
- dp_key_lo_o  out  1  XOR 0‖K into x3,x4
- dp_key_hi_o  out  1  XOR K‖0 into x1,x2
- dp_dom_sep_o  out  1  XOR DOM_SEP_CONST into x4
- tag_valid_o  out  1  datapath tag output valid
- tag_ready_i  in  1  tag consumed
- busy_o  out  1  state ≠ IDLE

## Operation
- States and transitions:
  - IDLE → LOAD on start_i.
  - LOAD (dp_load_init_o) → PERM, with p^a and return state POST_INIT.
  - PERM: dp_round_en_o=1 every cycle. The index register starts at 12−ROUNDS (p^a or p^b) and increments each round. After index 11 the FSM goes to the latched return state.
  - POST_INIT (dp_key_lo_o): if ad_empty → MSG_WAIT, also asserting dp_dom_sep_o in the same cycle. Otherwise → AD_WAIT.
  - AD_WAIT: ad_ready_o=1. On ad_valid_i: dp_absorb_o=1 that cycle, then PERM with p^b. Return state is DOM_SEP if ad_last_i, else AD_WAIT.
  - DOM_SEP (dp_dom_sep_o) → MSG_WAIT.
  - MSG_WAIT: msg_ready_o=1. On msg_valid_i: dp_absorb_o=1, and the datapath presents the ct/pt block in that cycle. If msg_last_i → FIN_KEY (no permutation). Otherwise → PERM with p^b, return MSG_WAIT.
  - FIN_KEY (dp_key_hi_o) → PERM with p^a, return TAG.
  - TAG: tag_valid_o=1, held until tag_ready_i. On tag_ready_i → IDLE.
- Output timing:
  - ready and strobe outputs are combinational from state.
  - dp_absorb_o = state-ready AND valid.
  - Inputs are never sampled outside their wait state.
  - dp_rnd_o = 0 whenever dp_round_en_o=0.
- start_i outside IDLE: ignored.
- abort_i: FSM → IDLE next cycle; latched flags and index cleared; no strobes in that cycle. abort_i has priority over every transition, including start_i in IDLE.
- Reset: state IDLE; all outputs 0; index 0; latched flags 0.

## Timing
- Reference timing for ROUNDS_A=12, ROUNDS_B=6, with start_i sampled high in cycle 0 and inputs valid as soon as ready:
  - LOAD at cycle 1.
  - p^a at cycles 2–13, dp_rnd_o = 0..11.
  - POST_INIT at cycle 14.
  - First wait state at cycle 15.
- Each p^b takes 6 cycles (indices 6..11). DOM_SEP takes 1 cycle.
- Last message block to tag_valid_o: 1 + 1 + ROUNDS_A cycles (FIN_KEY at +1, p^a, TAG at +14).
- Throughput: one AD or message block per ROUNDS_B+1 cycles.
- Valid deasserted in a wait state: the FSM stalls indefinitely with no strobes.

## Test plan
- No AD, 1 message block, encrypt, inputs always valid:
  - dp_load_init_o at cycle 1.
  - dp_round_en_o at cycles 2–13 with dp_rnd_o 0..11.
  - dp_key_lo_o and dp_dom_sep_o together at cycle 14.
  - dp_absorb_o at cycle 15, dp_key_hi_o at 16, rounds 17–28.
  - tag_valid_o at cycle 29.
  - With tag_ready_i=1, busy_o=0 at cycle 30.
- 1 AD + 1 message block:
  - AD absorb at cycle 15; p^b at 16–21 with dp_rnd_o 6..11.
  - dp_dom_sep_o at 22; message absorb at 23.
  - tag_valid_o at 37.
- 3 AD blocks, 2 message blocks, decrypt, valid gaps of 5 cycles:
  - Exactly 5 dp_absorb_o pulses, dp_decrypt_o=1 throughout.
  - 4 p^b runs and 2 p^a runs.
  - No strobes during the gaps.
- tag_ready_i held low for 10 cycles: tag_valid_o stays high for 10 cycles, then the FSM returns to IDLE one cycle after tag_ready_i rises.
- abort_i at the third p^b round, and separately in TAG:
  - Next cycle: busy_o=0 and all strobes 0.
  - A following start_i reproduces the cycle-exact sequence of the first scenario.
- Reset asserted mid-permutation (asynchronous, off clock edge):
  - Outputs go to 0 immediately.
  - start_i while busy (no reset) has no effect.
  - ROUNDS_A=8 build yields dp_rnd_o 4..11.

Source files
------------

// File: rtl/ascon_ctrl.sv
// Sequencing FSM for the Ascon-128 one-round-per-cycle datapath.
// Walks init, AD, message, finalisation and tag phases; carries no data.
module ascon_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       decrypt_i,
  input  logic       ad_empty_i,
  input  logic       abort_i,
  input  logic       ad_valid_i,
  input  logic       ad_last_i,
  output logic       ad_ready_o,
  input  logic       msg_valid_i,
  input  logic       msg_last_i,
  output logic       msg_ready_o,
  output logic       dp_load_init_o,
  output logic       dp_round_en_o,
  output logic [3:0] dp_rnd_o,
  output logic       dp_absorb_o,
  output logic       dp_decrypt_o,
  output logic       dp_key_lo_o,
  output logic       dp_key_hi_o,
  output logic       dp_dom_sep_o,
  output logic       tag_valid_o,
  input  logic       tag_ready_i,
  output logic       busy_o
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_PERM      = 4'd2;
  localparam logic [3:0] S_POST_INIT = 4'd3;
  localparam logic [3:0] S_AD_WAIT   = 4'd4;
  localparam logic [3:0] S_DOM_SEP   = 4'd5;
  localparam logic [3:0] S_MSG_WAIT  = 4'd6;
  localparam logic [3:0] S_FIN_KEY   = 4'd7;
  localparam logic [3:0] S_TAG       = 4'd8;

  // Round index runs up to 11 so the constant table is shared by p^a and p^b.
  localparam logic [3:0] RA_START = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RB_START = 4'(12 - ROUNDS_B);

  logic [3:0] state_q, state_d;
  logic [3:0] ret_q, ret_d;
  logic [3:0] idx_q, idx_d;
  logic       dec_q, dec_d;
  logic       ade_q, ade_d;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    ade_d   = ade_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_LOAD;
        dec_d   = decrypt_i;
        ade_d   = ad_empty_i;
      end
      S_LOAD: begin
        state_d = S_PERM;
        idx_d   = RA_START;
        ret_d   = S_POST_INIT;
      end
      S_PERM: begin
        if (idx_q == 4'd11) begin
          state_d = ret_q;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_POST_INIT: state_d = ade_q ? S_MSG_WAIT : S_AD_WAIT;
      S_AD_WAIT: if (ad_valid_i) begin
        state_d = S_PERM;
        idx_d   = RB_START;
        ret_d   = ad_last_i ? S_DOM_SEP : S_AD_WAIT;
      end
      S_DOM_SEP: state_d = S_MSG_WAIT;
      S_MSG_WAIT: if (msg_valid_i) begin
        if (msg_last_i) begin
          state_d = S_FIN_KEY;
        end else begin
          state_d = S_PERM;
          idx_d   = RB_START;
          ret_d   = S_MSG_WAIT;
        end
      end
      S_FIN_KEY: begin
        state_d = S_PERM;
        idx_d   = RA_START;
        ret_d   = S_TAG;
      end
      S_TAG: if (tag_ready_i) begin
        state_d = S_IDLE;
        dec_d   = 1'b0;
        ade_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      ret_d   = S_IDLE;
      idx_d   = 4'd0;
      dec_d   = 1'b0;
      ade_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      idx_q   <= 4'd0;
      dec_q   <= 1'b0;
      ade_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      ade_q   <= ade_d;
    end
  end

  // An aborting cycle must not disturb the datapath, so every strobe is gated.
  logic live;
  assign live = ~abort_i;

  assign ad_ready_o     = live & (state_q == S_AD_WAIT);
  assign msg_ready_o    = live & (state_q == S_MSG_WAIT);
  assign dp_load_init_o = live & (state_q == S_LOAD);
  assign dp_round_en_o  = live & (state_q == S_PERM);
  assign dp_rnd_o       = dp_round_en_o ? idx_q : 4'd0;
  assign dp_absorb_o    = (ad_ready_o & ad_valid_i) | (msg_ready_o & msg_valid_i);
  assign dp_decrypt_o   = dec_q;
  assign dp_key_lo_o    = live & (state_q == S_POST_INIT);
  assign dp_key_hi_o    = live & (state_q == S_FIN_KEY);
  assign dp_dom_sep_o   = live & ((state_q == S_DOM_SEP) | ((state_q == S_POST_INIT) & ade_q));
  assign tag_valid_o    = live & (state_q == S_TAG);
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ascon_ctrl.sv
// Directed bench for ascon_ctrl: cycle-exact phase traces, stalls, abort, reset.
module tb_ascon_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 0, decrypt_i = 0, ad_empty_i = 0, abort_i = 0;
  logic ad_valid_i = 0, ad_last_i = 0, msg_valid_i = 0, msg_last_i = 0, tag_ready_i = 0;
  logic ad_ready_o, msg_ready_o, dp_load_init_o, dp_round_en_o, dp_absorb_o, dp_decrypt_o;
  logic dp_key_lo_o, dp_key_hi_o, dp_dom_sep_o, tag_valid_o, busy_o;
  logic [3:0] dp_rnd_o;
  logic ad_ready8, msg_ready8, load8, ren8, absorb8, dec8, key_lo8, key_hi8, dom8, tag8, busy8;
  logic [3:0] rnd8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ascon_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .decrypt_i(decrypt_i),
    .ad_empty_i(ad_empty_i), .abort_i(abort_i), .ad_valid_i(ad_valid_i),
    .ad_last_i(ad_last_i), .ad_ready_o(ad_ready_o), .msg_valid_i(msg_valid_i),
    .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o), .dp_load_init_o(dp_load_init_o),
    .dp_round_en_o(dp_round_en_o), .dp_rnd_o(dp_rnd_o), .dp_absorb_o(dp_absorb_o),
    .dp_decrypt_o(dp_decrypt_o), .dp_key_lo_o(dp_key_lo_o), .dp_key_hi_o(dp_key_hi_o),
    .dp_dom_sep_o(dp_dom_sep_o), .tag_valid_o(tag_valid_o), .tag_ready_i(tag_ready_i),
    .busy_o(busy_o)
  );

  ascon_ctrl #(.ROUNDS_A(8), .ROUNDS_B(6)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .decrypt_i(decrypt_i),
    .ad_empty_i(ad_empty_i), .abort_i(abort_i), .ad_valid_i(ad_valid_i),
    .ad_last_i(ad_last_i), .ad_ready_o(ad_ready8), .msg_valid_i(msg_valid_i),
    .msg_last_i(msg_last_i), .msg_ready_o(msg_ready8), .dp_load_init_o(load8),
    .dp_round_en_o(ren8), .dp_rnd_o(rnd8), .dp_absorb_o(absorb8),
    .dp_decrypt_o(dec8), .dp_key_lo_o(key_lo8), .dp_key_hi_o(key_hi8),
    .dp_dom_sep_o(dom8), .tag_valid_o(tag8), .tag_ready_i(tag_ready_i),
    .busy_o(busy8)
  );

  // {load, round_en, rnd[3:0], absorb, key_lo, key_hi, dom_sep, tag_valid, ad_rdy, msg_rdy, busy, dec}
  logic [14:0] obs;
  assign obs = {dp_load_init_o, dp_round_en_o, dp_rnd_o, dp_absorb_o, dp_key_lo_o, dp_key_hi_o,
                dp_dom_sep_o, tag_valid_o, ad_ready_o, msg_ready_o, busy_o, dp_decrypt_o};
  localparam logic [14:0] STRB = 15'h7FF0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Hand-written per-cycle trace: cycle 0 is the cycle start_i is sampled.
  function automatic logic [14:0] exp_vec(input int c, input bit ad);
    logic [14:0] v;
    v = '0;
    if (c == 1) v[14] = 1'b1;
    if (c >= 2 && c <= 13) begin v[13] = 1'b1; v[12:9] = 4'(c - 2); end
    if (!ad) begin
      if (c == 14) begin v[7] = 1'b1; v[5] = 1'b1; end
      if (c == 15) begin v[8] = 1'b1; v[2] = 1'b1; end
      if (c == 16) v[6] = 1'b1;
      if (c >= 17 && c <= 28) begin v[13] = 1'b1; v[12:9] = 4'(c - 17); end
      if (c == 29) v[4] = 1'b1;
      v[1] = (c >= 1 && c <= 29);
    end else begin
      if (c == 14) v[7] = 1'b1;
      if (c == 15) begin v[8] = 1'b1; v[3] = 1'b1; end
      if (c >= 16 && c <= 21) begin v[13] = 1'b1; v[12:9] = 4'(c - 10); end
      if (c == 22) v[5] = 1'b1;
      if (c == 23) begin v[8] = 1'b1; v[2] = 1'b1; end
      if (c == 24) v[6] = 1'b1;
      if (c >= 25 && c <= 36) begin v[13] = 1'b1; v[12:9] = 4'(c - 25); end
      if (c == 37) v[4] = 1'b1;
      v[1] = (c >= 1 && c <= 37);
    end
    return v;
  endfunction

  task automatic run_seq(input bit ad, input bit trdy, input int spike, input bit chk8,
                         input int upto, input string nm);
    ad_empty_i = !ad; decrypt_i = 0;
    ad_valid_i = 1; ad_last_i = 1; msg_valid_i = 1; msg_last_i = 1;
    tag_ready_i = trdy; start_i = 1;
    for (int c = 1; c <= upto; c++) begin
      adv();
      start_i = (c == spike);
      #1;
      chk($sformatf("%s c%0d", nm, c), 32'(obs), 32'(exp_vec(c, ad)));
      if (chk8 && c >= 2 && c <= 9) chk($sformatf("ra8 rnd c%0d", c), {ren8, rnd8}, {1'b1, 4'(c + 2)});
      if (chk8 && c == 10) chk("ra8 key_lo", 32'(key_lo8), 1);
    end
    start_i = 0;
  endtask

  initial begin
    int wt, nabs, na, nm, npa, npb;
    bit prev_ren, gap_bad, dec_bad, done;

    #7;
    chk("reset outs", 32'({obs, ren8, rnd8, busy8}), 0);
    rst_n = 1;
    adv();

    // no AD, one message block, ROUNDS_A=8 build alongside
    run_seq(0, 1, 0, 1, 30, "s1");
    // one AD block, one message block
    run_seq(1, 1, 0, 0, 38, "s2");

    // tag sink stalls for 10 cycles
    run_seq(0, 0, 0, 0, 29, "th");
    for (int c = 30; c <= 39; c++) begin
      adv();
      tag_ready_i = (c == 39);
      #1;
      chk($sformatf("tag hold c%0d", c), 32'(tag_valid_o), 1);
    end
    adv(); #1;
    chk("tag release busy", 32'(busy_o), 0);

    // abort on third p^b round, then a clean rerun
    run_seq(1, 1, 0, 0, 17, "ab");
    adv(); abort_i = 1; #1;
    chk("abort pb strobes", 32'(obs & STRB), 0);
    adv(); abort_i = 0; #1;
    chk("abort pb next", 32'(obs), 0);
    run_seq(0, 1, 0, 0, 30, "rerun");

    // abort in TAG
    run_seq(0, 0, 0, 0, 29, "at");
    abort_i = 1; #1;
    chk("abort tag strobes", 32'(obs & STRB), 0);
    adv(); abort_i = 0; tag_ready_i = 1; #1;
    chk("abort tag next", 32'(obs), 0);

    // abort beats start in IDLE
    start_i = 1; abort_i = 1;
    adv(); start_i = 0; abort_i = 0; #1;
    chk("abort vs start", 32'(busy_o), 0);

    // asynchronous reset mid-permutation
    run_seq(0, 1, 0, 0, 6, "rs");
    #1 rst_n = 0;
    #1 chk("async reset", 32'({obs, busy8}), 0);
    #2 rst_n = 1;
    adv();

    // start pulse while busy must be ignored
    run_seq(0, 1, 5, 0, 30, "spk");

    // 3 AD + 2 message blocks, decrypt, 5-cycle valid gaps
    ad_empty_i = 0; decrypt_i = 1; tag_ready_i = 1;
    ad_valid_i = 0; msg_valid_i = 0; start_i = 1;
    wt = 0; nabs = 0; na = 0; nm = 0; npa = 0; npb = 0;
    prev_ren = 0; gap_bad = 0; dec_bad = 0; done = 0;
    adv(); start_i = 0; decrypt_i = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      ad_valid_i = 0; msg_valid_i = 0;
      ad_last_i = (na == 2); msg_last_i = (nm == 1);
      #0;
      if (ad_ready_o || msg_ready_o) begin
        wt++;
        if (wt > 5) begin
          ad_valid_i = ad_ready_o; msg_valid_i = msg_ready_o; wt = 0;
        end
      end
      #1;
      if (!ad_valid_i && !msg_valid_i && (ad_ready_o || msg_ready_o) && (obs & STRB) != 0) gap_bad = 1;
      if (dp_absorb_o) begin
        nabs++;
        if (ad_ready_o) na++; else nm++;
      end
      if (dp_round_en_o && !prev_ren) begin
        if (dp_rnd_o == 4'd0) npa++;
        else if (dp_rnd_o == 4'd6) npb++;
      end
      prev_ren = dp_round_en_o;
      if (busy_o && !dp_decrypt_o) dec_bad = 1;
      if (!busy_o) done = 1;
      else adv();
    end
    chk("s3 finished", 32'(done), 1);
    chk("s3 absorbs", 32'(nabs), 5);
    chk("s3 pb runs", 32'(npb), 4);
    chk("s3 pa runs", 32'(npa), 2);
    chk("s3 gap strobes", 32'(gap_bad), 0);
    chk("s3 decrypt flag", 32'(dec_bad), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
